// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising per-core data-memory requests onto one single-ported memory.
// Optional bus locking for atomic read-modify-write is enabled by defining DM_ARB_LOCK_EN.
module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_lock,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SEL_W-1:0]       rr_ptr_q;
  logic [SEL_W-1:0]       sel_q;
  logic [NUM_CORES-1:0]   gnt_q;
  logic [NUM_CORES-1:0]   rvalid_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   mem_en_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic                   busy_q;

  logic [NUM_CORES-1:0]   cand_d;
  logic [SEL_W-1:0]       base_d;
  logic [SEL_W-1:0]       idx_d;
  logic [SEL_W-1:0]       pick_d;
  logic                   found_d;
  logic                   owner_clr_d;

`ifdef DM_ARB_LOCK_EN
  logic [SEL_W-1:0]       owner_q;
  logic                   owner_vld_q;
`else
  logic                   lock_unused;
  assign lock_unused = ^core_lock;
`endif

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
    int s;
    s = (int'(a) + b) % NUM_CORES;
    return SEL_W'(s);
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_CORES-1:0] v;
    v    = {NUM_CORES{1'b0}};
    v[s] = 1'b1;
    return v;
  endfunction

  // Request selection: first candidate at or after the search base, wrapping around.
  always_comb begin
    cand_d      = core_req;
    base_d      = rr_ptr_q;
    owner_clr_d = 1'b0;
`ifdef DM_ARB_LOCK_EN
    if (owner_vld_q) begin
      if (core_lock[owner_q]) begin
        cand_d = core_req & onehot(owner_q);
      end else begin
        // Owner released the bus: round-robin resumes just past it.
        owner_clr_d = 1'b1;
        base_d      = wrap_add(owner_q, 32'sd1);
      end
    end else begin
      owner_clr_d = 1'b0;
    end
`endif
    found_d = 1'b0;
    pick_d  = {SEL_W{1'b0}};
    idx_d   = {SEL_W{1'b0}};
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx_d = wrap_add(base_d, i);
      if (cand_d[idx_d]) begin
        found_d = 1'b1;
        pick_d  = idx_d;
      end else begin
        found_d = found_d;
      end
    end
  end

  // Main FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {SEL_W{1'b0}};
      sel_q       <= {SEL_W{1'b0}};
      gnt_q       <= {NUM_CORES{1'b0}};
      rvalid_q    <= {NUM_CORES{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
`ifdef DM_ARB_LOCK_EN
      owner_q     <= {SEL_W{1'b0}};
      owner_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q    <= {NUM_CORES{1'b0}};
          rvalid_q <= {NUM_CORES{1'b0}};
          mem_en_q <= 1'b0;
          if (owner_clr_d) begin
`ifdef DM_ARB_LOCK_EN
            owner_vld_q <= 1'b0;
`endif
            rr_ptr_q <= base_d;
          end
          if (found_d) begin
            sel_q       <= pick_d;
            gnt_q       <= onehot(pick_d);
            mem_en_q    <= 1'b1;
            mem_we_q    <= core_we[pick_d];
            mem_addr_q  <= core_addr[int'(pick_d)*ADDR_W +: ADDR_W];
            mem_wdata_q <= core_wdata[int'(pick_d)*DATA_W +: DATA_W];
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q    <= {NUM_CORES{1'b0}};
          mem_en_q <= 1'b0;
`ifdef DM_ARB_LOCK_EN
          if (core_lock[sel_q]) begin
            owner_q     <= sel_q;
            owner_vld_q <= 1'b1;
          end else begin
            rr_ptr_q <= wrap_add(sel_q, 32'sd1);
          end
`else
          rr_ptr_q <= wrap_add(sel_q, 32'sd1);
`endif
          if (mem_we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= onehot(sel_q);
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          gnt_q    <= {NUM_CORES{1'b0}};
          rvalid_q <= {NUM_CORES{1'b0}};
          mem_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign core_gnt    = gnt_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus queues expected grants/read returns with their cycle,
// a negedge monitor pops and compares them whenever the DUT presents a grant or read return.
module tb_dm_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    core_req;
  logic [N-1:0]    core_we;
  logic [N-1:0]    core_lock;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_gnt;
  logic [N-1:0]    core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = 16'h0000;
  logic            busy;

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten locations read as {8'hA0, addr[7:0]}; one-cycle read latency.
  logic [DW-1:0] mem [0:255];
  bit            written [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : {8'hA0, mem_addr[7:0]};
  end

  typedef struct {int cyc; logic [N-1:0] gnt; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} gexp_t;
  typedef struct {int cyc; logic [N-1:0] vld; logic [DW-1:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  task automatic exp_gnt(input int c, input int core, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    gexp_t e;
    e.cyc = c; e.gnt = 4'b0001 << core; e.we = we; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic exp_rd(input int c, input int core, input logic [DW-1:0] d);
    rexp_t e;
    e.cyc = c; e.vld = 4'b0001 << core; e.data = d;
    rq.push_back(e);
  endtask

  task automatic set_core(input int core, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_we[core]              = we;
    core_addr[core*AW +: AW]   = a;
    core_wdata[core*DW +: DW]  = d;
  endtask

  // Drive point is always 1 time unit after a rising edge.
  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    core_req = 4'b0000;
    rst_n    = 1'b0;
    wait_until(cyc + 2);
    rst_n    = 1'b1;
  endtask

  // Monitor: compare against the scoreboard whenever the DUT shows a grant/strobe or read return.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (core_gnt !== 4'b0000 || mem_en !== 1'b0) begin
        if (gq.size() == 0) begin
          unexpected("unexpected_gnt", {59'd0, mem_en, core_gnt});
        end else begin
          mg = gq.pop_front();
          chk("gnt_cycle", cyc, mg.cyc);
          chk("core_gnt", core_gnt, mg.gnt);
          chk("mem_en", mem_en, 1'b1);
          chk("mem_we", mem_we, mg.we);
          chk("mem_addr", mem_addr, mg.addr);
          chk("mem_wdata", mem_wdata, mg.wdata);
          chk("busy_in_issue", busy, 1'b1);
        end
      end
      if (core_rvalid !== 4'b0000) begin
        if (rq.size() == 0) begin
          unexpected("unexpected_rvalid", core_rvalid);
        end else begin
          mr = rq.pop_front();
          chk("rvalid_cycle", cyc, mr.cyc);
          chk("core_rvalid", core_rvalid, mr.vld);
          chk("core_rdata", core_rdata, mr.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int k;

  initial begin
    rst_n      = 1'b0;
    core_req   = 4'b1111;
    core_we    = 4'b0000;
    core_lock  = 4'b0000;
    core_addr  = {(N*AW){1'b0}};
    core_wdata = {(N*DW){1'b0}};
    set_core(0, 1'b0, 16'h0020, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", core_gnt, 4'b0000);
    chk("rst_rvalid", core_rvalid, 4'b0000);
    chk("rst_rdata", core_rdata, 16'h0000);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_busy", busy, 1'b0);

    // Release with all cores requesting: core 0 wins first.
    k = cyc;
    rst_n = 1'b1;
    exp_gnt(k + 1, 0, 1'b0, 16'h0020, 16'h0000);
    exp_rd(k + 3, 0, 16'hA020);
    wait_until(k + 1);
    core_req = 4'b0000;
    wait_until(k + 4);
    chk("idle_busy", busy, 1'b0);

    // Single write from core 2.
    set_core(2, 1'b1, 16'h0010, 16'hBEEF);
    k = cyc;
    core_req = 4'b0100;
    exp_gnt(k + 1, 2, 1'b1, 16'h0010, 16'hBEEF);
    wait_until(k + 1);
    core_req = 4'b0000;
    wait_until(k + 3);

    // Single read from core 1 of the word just written.
    set_core(1, 1'b0, 16'h0010, 16'h0000);
    k = cyc;
    core_req = 4'b0010;
    exp_gnt(k + 1, 1, 1'b0, 16'h0010, 16'h0000);
    exp_rd(k + 3, 1, 16'hBEEF);
    wait_until(k + 1);
    core_req = 4'b0000;
    wait_until(k + 4);
    chk("rdata_hold", core_rdata, 16'hBEEF);

    // Reset during RESP of a core-1 read: no rvalid may follow.
    k = cyc;
    core_req = 4'b0010;
    exp_gnt(k + 1, 1, 1'b0, 16'h0010, 16'h0000);
    wait_until(k + 1);
    core_req = 4'b0000;
    wait_until(k + 2);
    rst_n = 1'b0;
    wait_until(k + 4);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rvalid", core_rvalid, 4'b0000);
    rst_n = 1'b1;

    // rr_ptr back to 0: cores 0 and 2 write together, core 0 first.
    set_core(0, 1'b1, 16'h0040, 16'h5A5A);
    set_core(2, 1'b1, 16'h0042, 16'hA5A5);
    k = cyc;
    core_req = 4'b0101;
    exp_gnt(k + 1, 0, 1'b1, 16'h0040, 16'h5A5A);
    exp_gnt(k + 3, 2, 1'b1, 16'h0042, 16'hA5A5);
    wait_until(k + 1);
    core_req = 4'b0100;
    wait_until(k + 3);
    core_req = 4'b0000;
    wait_until(k + 5);

    // Fairness: all four cores read continuously after a fresh reset.
    reset_dut();
    for (int i = 0; i < N; i++) set_core(i, 1'b0, 16'h0030 + 16'(i), 16'h0000);
    k = cyc;
    core_req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      exp_gnt(k + 1 + 3*j, j % 4, 1'b0, 16'h0030 + 16'(j % 4), 16'h0000);
      exp_rd(k + 3 + 3*j, j % 4, 16'hA030 + 16'(j % 4));
    end
    wait_until(k + 16);
    core_req = 4'b0000;
    wait_until(k + 20);

`ifdef DM_ARB_LOCK_EN
    // Locked read-modify-write by core 3 while cores 0 and 1 wait.
    set_core(3, 1'b0, 16'h0033, 16'h0000);
    set_core(0, 1'b1, 16'h0050, 16'h0101);
    set_core(1, 1'b1, 16'h0051, 16'h0202);
    core_lock = 4'b1000;
    k = cyc;
    core_req = 4'b1011;
    exp_gnt(k + 1, 3, 1'b0, 16'h0033, 16'h0000);
    exp_rd(k + 3, 3, 16'hA033);
    wait_until(k + 1);
    core_req = 4'b0011;
    wait_until(k + 2);
    set_core(3, 1'b1, 16'h0033, 16'hC0DE);
    core_req = 4'b1011;
    exp_gnt(k + 4, 3, 1'b1, 16'h0033, 16'hC0DE);
    exp_gnt(k + 6, 0, 1'b1, 16'h0050, 16'h0101);
    exp_gnt(k + 8, 1, 1'b1, 16'h0051, 16'h0202);
    wait_until(k + 4);
    core_req  = 4'b0011;
    core_lock = 4'b0000;
    wait_until(k + 6);
    core_req = 4'b0010;
    wait_until(k + 8);
    core_req = 4'b0000;
    wait_until(k + 10);
`endif

    wait_until(cyc + 4);
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rvalid_queue_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shared data-memory arbiter sitting directly downstream of the processor cores' data-memory port.
- Each core presents address, write data and write-enable. The arbiter serialises requests onto one single-ported data memory using round-robin arbitration.
- Read data is returned to the requesting core on the DM_out path.
- Lets several processor instances share one data memory in the multi-core build.

Parameters:
- NUM_CORES, 4, number of requesting cores (1..8)
- ADDR_W, 16, memory address width
- DATA_W, 16, data width

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active low
- core_req  input  NUM_CORES  per-core access request; held until core_gnt seen
- core_we  input  NUM_CORES  per-core write enable (1=write, 0=read)
- core_lock  input  NUM_CORES  per-core bus-lock request (used only with DM_ARB_LOCK_EN)
- core_addr  input  NUM_CORES*ADDR_W  flattened addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  input  NUM_CORES*DATA_W  flattened write data, same packing
- core_gnt  output  NUM_CORES  one-hot, one-cycle pulse: request accepted and issued
- core_rvalid  output  NUM_CORES  one-hot, one-cycle pulse: core_rdata valid for that core
- core_rdata  output  DATA_W  read data, broadcast to all cores
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid exactly 1 cycle after mem_en with mem_we=0
- busy  output  1  high whenever state != IDLE

Behaviour:
- Single clock, synchronous active-low reset. All state and outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, all outputs 0, lock owner cleared.

FSM states:
- IDLE:
  - If any core_req is high, select the first requesting core searching from rr_ptr upward, wrapping modulo NUM_CORES.
  - Capture sel, addr, we and wdata; go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata = captured values; core_gnt[sel]=1.
  - rr_ptr <= (sel+1) mod NUM_CORES.
  - Write: next state IDLE. Read: next state RESP.
- RESP (1 cycle):
  - core_rdata <= mem_rdata; core_rvalid[sel] is set, visible in the following cycle (a one-cycle pulse); next state IDLE.

Timing:
- Write: request sampled at edge N; gnt and mem_en high in cycle N+1.
- Read: core_rvalid high in cycle N+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.

Output rules:
- mem_en is low in IDLE and RESP. mem_addr, mem_wdata and mem_we hold their last values when idle.
- core_rdata holds until the next read completes.

Boundary conditions:
- Request is committed at capture. Dropping core_req after capture does not cancel the access.
- A core must drop core_req in the cycle after core_gnt. If core_req is still high in IDLE, it is treated as a new request.
- All cores requesting continuously: grants go 0,1,2,3,0,... with no starvation.
- NUM_CORES=1: rr_ptr is constant 0.
- Reset mid-operation: the access is abandoned, and no gnt or rvalid pulse is issued afterwards.
- core_lock is ignored when the macro is off.

Optional Feature:
- DM_ARB_LOCK_EN defined:
  - If core_lock[sel] is high during ISSUE, sel becomes lock owner and rr_ptr is not advanced.
  - While an owner exists, IDLE considers only the owner's core_req.
  - Ownership is cleared in IDLE when core_lock[owner]=0; normal round-robin then resumes from owner+1.
  - Reset clears ownership.
  - Provides atomic read-modify-write.
- DM_ARB_LOCK_EN undefined: core_lock is unused and arbitration is pure round-robin.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with core_req=4'b1111 -> all outputs 0 and busy=0. After release, the first grant goes to core 0.
- Single write: core 2 writes addr 0x0010, data 0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF and core_gnt=4'b0100 all in the same cycle, 1 cycle after request sampling.
- Single read: core 1 reads 0x0010, memory model returns 0xBEEF -> core_rvalid=4'b0010 and core_rdata=0xBEEF, 3 cycles after request sampling.
- Fairness: all four cores request reads continuously -> grant order 0,1,2,3,0,1; each core is served once per 12 cycles.
- Reset mid-read: assert rst_n=0 during RESP -> no core_rvalid pulse, state returns to IDLE, rr_ptr=0.
- Lock (DM_ARB_LOCK_EN): core 3 reads with lock held while cores 0 and 1 request -> core 3's following write is granted next. After core_lock[3] drops, the next grant goes to core 0.
